// File: rtl/parity_frame_ctrl.sv
// Frames a byte stream into FRAME_LEN-byte frames, checks per-byte parity and counts bad frames.
// Optional macro PARITY_ERR_IDX_EN adds first_err_idx (index of first bad byte in the last frame).
module parity_frame_ctrl #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             odd_mode,
  input  logic             clr_cnt,
  input  logic [7:0]       s_data,
  input  logic             s_par,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             byte_err,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
`ifdef PARITY_ERR_IDX_EN
  ,
  output logic [7:0]       first_err_idx
`endif
);

  localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_cnt;
  logic             r_acc;
  logic             r_byte_err;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_accept;
  logic w_par;
  logic w_mis;
  logic w_last;

  assign w_accept = s_valid && (r_state == S_RUN);
  assign w_par    = ^{s_data, s_par};
  // Odd mode expects an odd number of ones across data and parity bit.
  assign w_mis    = odd_mode ? ~w_par : w_par;
  assign w_last   = w_accept && (r_cnt == LAST_IDX);

  assign s_ready    = (r_state == S_RUN);
  assign frame_done = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign byte_err   = r_byte_err;
  assign frame_err  = r_frame_err;
  assign err_cnt    = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= 1'b0;
      r_byte_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_err <= w_accept && w_mis;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_acc <= r_acc | w_mis;
            if (w_last) begin
              r_state     <= S_DONE;
              r_frame_err <= r_acc | w_mis;
            end else begin
              r_cnt <= r_cnt + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= en ? S_RUN : S_IDLE;
          r_cnt   <= '0;
          r_acc   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Clear wins over an increment landing in the same DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (clr_cnt) begin
      r_err_cnt <= '0;
    end else if ((r_state == S_DONE) && r_frame_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

`ifdef PARITY_ERR_IDX_EN
  logic [7:0] r_first;
  logic [7:0] r_first_err_idx;

  assign first_err_idx = r_first_err_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first         <= 8'hFF;
      r_first_err_idx <= 8'hFF;
    end else if (r_state != S_RUN) begin
      r_first <= 8'hFF;
    end else if (w_accept) begin
      if (w_mis && !r_acc) begin
        r_first <= 8'(r_cnt);
      end
      if (w_last) begin
        r_first_err_idx <= r_acc ? r_first : (w_mis ? 8'(r_cnt) : 8'hFF);
      end
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed plus randomized bench for parity_frame_ctrl with a frame-level reference model.
module tb_parity_frame_ctrl;

  localparam int FL    = 4;
  localparam int CW    = 2;
  localparam int CMAX  = 3;

  logic          clk = 1'b0;
  logic          rst_n, en, odd_mode, clr_cnt, s_par, s_valid;
  logic [7:0]    s_data;
  logic          s_ready, byte_err, frame_done, frame_err, busy;
  logic [CW-1:0] err_cnt;
`ifdef PARITY_ERR_IDX_EN
  logic [7:0]    first_err_idx;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int model_cnt = 0;
  logic [7:0] fd [FL];
  logic       fp [FL];
  logic       fm [FL];
  int         fg [FL];

  parity_frame_ctrl #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .odd_mode(odd_mode), .clr_cnt(clr_cnt),
    .s_data(s_data), .s_par(s_par), .s_valid(s_valid), .s_ready(s_ready),
    .byte_err(byte_err), .frame_done(frame_done), .frame_err(frame_err),
    .err_cnt(err_cnt), .busy(busy)
`ifdef PARITY_ERR_IDX_EN
    , .first_err_idx(first_err_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Parity rule: odd mode wants an odd count of ones over {data,par}, even mode an even count.
  function automatic logic bad_byte(input logic [7:0] d, input logic p, input logic odd);
    int ones;
    ones = $countones({d, p});
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic set4(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [7:0] d3, input logic [3:0] p, input logic m, input int g);
    fd[0] = d0; fd[1] = d1; fd[2] = d2; fd[3] = d3;
    for (int i = 0; i < FL; i++) begin
      fp[i] = p[i];
      fm[i] = m;
      fg[i] = (i == 0) ? 0 : g;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_byte_err"}, byte_err, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef PARITY_ERR_IDX_EN
    check({tag, "_first_idx"}, first_err_idx, 8'hFF);
`endif
  endtask

  // Runs one frame from RUN state; clr asserts clr_cnt during DONE, drop lowers en after byte 0.
  task automatic run_frame(input string tag, input logic clr, input logic drop);
    logic mis, bad;
    int first;
    bad = 1'b0;
    first = 255;
    for (int i = 0; i < FL; i++) begin
      for (int k = 0; k < fg[i]; k++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        tick();
        check({tag, "_gap_ready"}, s_ready, 1);
        check({tag, "_gap_byte_err"}, byte_err, 0);
        check({tag, "_gap_done"}, frame_done, 0);
      end
      s_data = fd[i]; s_par = fp[i]; odd_mode = fm[i]; s_valid = 1'b1;
      check({tag, "_ready"}, s_ready, 1);
      mis = bad_byte(fd[i], fp[i], fm[i]);
      if (mis && !bad) first = i;
      bad = bad | mis;
      tick();
      if (drop && i == 0) en = 1'b0;
      check({tag, "_byte_err"}, byte_err, mis);
      check({tag, "_frame_done"}, frame_done, (i == FL - 1));
    end
    s_valid = 1'b0;
    check({tag, "_frame_err"}, frame_err, bad);
    check({tag, "_done_ready"}, s_ready, 0);
    check({tag, "_done_busy"}, busy, 1);
`ifdef PARITY_ERR_IDX_EN
    check({tag, "_first_idx"}, first_err_idx, bad ? first : 8'hFF);
`endif
    if (clr) model_cnt = 0;
    else if (bad && model_cnt < CMAX) model_cnt++;
    clr_cnt = clr;
    tick();
    clr_cnt = 1'b0;
    check({tag, "_err_cnt"}, err_cnt, model_cnt);
    check({tag, "_after_done"}, frame_done, 0);
    check({tag, "_err_hold"}, frame_err, bad);
    check({tag, "_next_ready"}, s_ready, en);
    $display("frame %s: frame_err=%0d err_cnt=%0d", tag, frame_err, err_cnt);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; odd_mode = 1'b0; clr_cnt = 1'b0;
    s_data = 8'h00; s_par = 1'b0; s_valid = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check("idle_no_en_ready", s_ready, 0);
    en = 1'b1;
    tick();

    set4(8'h01, 8'h03, 8'h00, 8'hFF, 4'b1110, 1'b1, 0);
    run_frame("clean", 1'b0, 1'b0);
    set4(8'h01, 8'h03, 8'h07, 8'h00, 4'b0001, 1'b0, 0);
    run_frame("even_bad2", 1'b0, 1'b0);
    set4(8'h01, 8'h03, 8'h00, 8'hFF, 4'b1110, 1'b1, 2);
    run_frame("stall", 1'b0, 1'b0);

    set4(8'h01, 8'h01, 8'h01, 8'h01, 4'b0000, 1'b0, 0);
    run_frame("bad_clr", 1'b1, 1'b0);
    for (int f = 0; f < 5; f++) run_frame("sat", 1'b0, 1'b0);
    run_frame("sat_clr", 1'b1, 1'b0);

    set4(8'h01, 8'h03, 8'h00, 8'hFF, 4'b1110, 1'b1, 0);
    run_frame("en_drop", 1'b0, 1'b1);
    tick();
    check("en_drop_idle_ready", s_ready, 0);
    check("en_drop_idle_busy", busy, 0);

    en = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      s_data = 8'h01; s_par = 1'b1; odd_mode = 1'b0; s_valid = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    model_cnt = 0;
    check_reset_outputs("mid_reset");
    s_valid = 1'b0;
    tick();
    check("mid_reset_no_done", frame_done, 0);
    rst_n = 1'b1;
    tick();
    set4(8'h07, 8'h00, 8'h03, 8'h01, 4'b1001, 1'b0, 0);
    run_frame("post_reset", 1'b0, 1'b0);

    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < FL; i++) begin
        fd[i] = 8'($urandom);
        fp[i] = 1'($urandom);
        fm[i] = 1'($urandom);
        fg[i] = int'($urandom_range(0, 2));
      end
      run_frame("rand", ($urandom % 4) == 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
